// File: rtl/br_resolve_queue.sv
// rtl/br_resolve_queue.sv - in-order branch resolution queue feeding the branch mask controller
// Accepts up to two resolved branches per cycle and issues one per cycle, keeping queued dep masks coherent.
module br_resolve_queue #(
  parameter int BR_MASK_W = 5,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex0_valid_i,
  input  logic                     ex0_mispred_i,
  input  logic [BR_MASK_W-1:0]     ex0_dep_mask_i,
  input  logic [BR_MASK_W-1:0]     ex0_br_bit_i,
  input  logic                     ex1_valid_i,
  input  logic                     ex1_mispred_i,
  input  logic [BR_MASK_W-1:0]     ex1_dep_mask_i,
  input  logic [BR_MASK_W-1:0]     ex1_br_bit_i,
  output logic                     ex_ready_o,
  output logic [1:0]               br_state_o,
  output logic [BR_MASK_W-1:0]     br_dep_mask_o,
  output logic [BR_MASK_W-1:0]     rs_iss2br_mask_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int N  = DEPTH + 2;

  localparam logic [1:0] BR_PR_NONE    = 2'b00;
  localparam logic [1:0] BR_PR_WRONG   = 2'b01;
  localparam logic [1:0] BR_PR_CORRECT = 2'b10;

  logic [DEPTH-1:0]     q_mis_q, q_mis_d;
  logic [BR_MASK_W-1:0] q_dep_q [DEPTH];
  logic [BR_MASK_W-1:0] q_dep_d [DEPTH];
  logic [BR_MASK_W-1:0] q_bit_q [DEPTH];
  logic [BR_MASK_W-1:0] q_bit_d [DEPTH];
  logic [CW-1:0]        count_q, count_d;

  logic [1:0]           st_q, st_d;
  logic [BR_MASK_W-1:0] own_q, own_d;
  logic [BR_MASK_W-1:0] dep_q, dep_d;

  // Candidate list: queue slots first, then ex0, then ex1, which is program order.
  logic [N-1:0]         c_vld;
  logic [N-1:0]         c_mis;
  logic [BR_MASK_W-1:0] c_dep [N];
  logic [BR_MASK_W-1:0] c_bit [N];
  int                   ptr;

  assign ex_ready_o = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    c_vld   = '0;
    c_mis   = '0;
    q_mis_d = '0;
    st_d    = BR_PR_NONE;
    own_d   = '0;
    dep_d   = '0;
    ptr     = 0;
    for (int i = 0; i < N; i++) begin
      c_dep[i] = '0;
      c_bit[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      q_dep_d[i] = '0;
      q_bit_d[i] = '0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      c_vld[i] = (i < int'(count_q));
      c_mis[i] = q_mis_q[i];
      c_dep[i] = q_dep_q[i];
      c_bit[i] = q_bit_q[i];
    end
    c_vld[DEPTH]   = ex0_valid_i & ex_ready_o;
    c_mis[DEPTH]   = ex0_mispred_i;
    c_dep[DEPTH]   = ex0_dep_mask_i;
    c_bit[DEPTH]   = ex0_br_bit_i;
    c_vld[DEPTH+1] = ex1_valid_i & ex_ready_o;
    c_mis[DEPTH+1] = ex1_mispred_i;
    c_dep[DEPTH+1] = ex1_dep_mask_i;
    c_bit[DEPTH+1] = ex1_br_bit_i;

    // The resolution currently on the outputs squashes or frees its bit first.
    for (int i = 0; i < N; i++) begin
      if (st_q == BR_PR_WRONG && |(c_dep[i] & own_q)) begin
        c_vld[i] = 1'b0;
      end else if (st_q == BR_PR_CORRECT) begin
        c_dep[i] = c_dep[i] & ~own_q;
      end
    end

    if (c_vld[0]) begin
      st_d     = c_mis[0] ? BR_PR_WRONG : BR_PR_CORRECT;
      own_d    = c_bit[0];
      dep_d    = c_dep[0];
      c_vld[0] = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      if (st_d == BR_PR_WRONG && |(c_dep[i] & own_d)) begin
        c_vld[i] = 1'b0;
      end else if (st_d == BR_PR_CORRECT) begin
        c_dep[i] = c_dep[i] & ~own_d;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (c_vld[i] && ptr < DEPTH) begin
        q_mis_d[AW'(ptr)] = c_mis[i];
        q_dep_d[AW'(ptr)] = c_dep[i];
        q_bit_d[AW'(ptr)] = c_bit[i];
        ptr = ptr + 1;
      end
    end
    count_d = CW'(ptr);
  end

  always_ff @(posedge clk) begin
    q_mis_q <= q_mis_d;
    q_dep_q <= q_dep_d;
    q_bit_q <= q_bit_d;
    if (rst) begin
      count_q <= '0;
      st_q    <= BR_PR_NONE;
      own_q   <= '0;
      dep_q   <= '0;
    end else begin
      count_q <= count_d;
      st_q    <= st_d;
      own_q   <= own_d;
      dep_q   <= dep_d;
    end
  end

  assign br_state_o       = st_q;
  assign br_dep_mask_o    = (st_q != BR_PR_NONE) ? (own_q - BR_MASK_W'(1)) : '0;
  assign rs_iss2br_mask_o = (st_q != BR_PR_NONE) ? dep_q : '0;
  assign count_o          = count_q;

endmodule

// File: doc/br_resolve_queue.md
Name: br_resolve_queue

Overview:
- Producer side of the branch-resolution interface consumed by the branch mask controller.
- Collects resolved branches from two execute-stage branch units, up to 2 per cycle.
- Buffers them in order in a small compacting queue and issues at most one resolution per cycle as {br_state, br_dep_mask, rs_iss2br_mask}.
- Keeps queued masks coherent as bits are freed by CORRECT resolutions, and drops queued branches squashed by a WRONG resolution.

Parameters:
- BR_MASK_W, 5, branch mask width; one bit per in-flight branch.
- DEPTH, 4, queue entries; must be at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ex0_valid_i  in  1  branch unit 0 resolved a branch this cycle
- ex0_mispred_i  in  1  1 = prediction wrong
- ex0_dep_mask_i  in  BR_MASK_W  mask the branch depends on; its own bit is excluded
- ex0_br_bit_i  in  BR_MASK_W  one-hot own branch bit
- ex1_valid_i, ex1_mispred_i, ex1_dep_mask_i, ex1_br_bit_i  in  1/1/BR_MASK_W/BR_MASK_W  same as ex0; ex1 is younger than ex0 when both are valid
- ex_ready_o  out  1  both ex ports may present this cycle
- br_state_o  out  2  `BR_PR_NONE=2'b00, `BR_PR_WRONG=2'b01, `BR_PR_CORRECT=2'b10
- br_dep_mask_o  out  BR_MASK_W  own_bit-1; all bits below the own bit set, so the first zero is the own bit
- rs_iss2br_mask_o  out  BR_MASK_W  current dep mask of the resolving branch; used for recovery AND
- count_o  out  log2(DEPTH)+1  valid queue entries

Behaviour:
- Entry = {mispred, dep_mask, br_bit}. Shift-compacting queue; entry 0 is the head.
- Output register holds {state, own_bit, dep_mask}.
  - br_dep_mask_o = own_bit-1 when state != NONE, else 0.
  - rs_iss2br_mask_o = stored dep_mask when state != NONE, else 0.
- Reset: queue empty, count_o=0, br_state_o=NONE, all mask outputs 0, ex_ready_o=1.
- ex_ready_o = (count_o <= DEPTH-2), combinational from registered count.
  - ex inputs presented while ex_ready_o=0 are ignored; the ex units hold them.
- At every posedge, in order:
  1. Retire filter: if the output register is WRONG with bit R, drop every queued entry and every accepted ex input whose dep_mask has R set. If it is CORRECT with bit R, clear R in those dep_masks.
  2. Pop: if the head survives step 1, load it into the output register as WRONG or CORRECT. Otherwise the output register becomes NONE.
  3. Pop filter: apply the step-1 rule with the popped head's bit and state to the remaining entries and to accepted ex inputs.
  4. Enqueue surviving ex0, then ex1, behind the remaining entries. Compact with no holes. count_o is updated.
- Latency: an ex input sampled at edge k appears on the outputs no earlier than after edge k+1. There is no bypass.
- Throughput: one resolution per cycle. Each output is valid for exactly one cycle.
- An entry with br_bit == the filtering bit cannot occur; behaviour in that case is undefined.
- After a WRONG is popped, older entries (filtering bit clear) remain and issue in order.
- rst asserted mid-operation discards all entries and the output resolution at that edge.

Test Plan:
1. Single CORRECT: ex0 valid, mispred=0, dep=00000, bit=00001 sampled at edge 1 -> cycle after edge 2: br_state=CORRECT, br_dep_mask_o=00000, rs_iss2br_mask_o=00000. Next cycle br_state=NONE, count_o=0.
2. Dual enqueue: ex0 bit=00001 dep=00000 and ex1 bit=00010 dep=00001, both CORRECT, same edge -> CORRECT with dep_o=00000, then CORRECT with dep_o=00001 and rs_iss2br_mask_o=00000, because bit0 was cleared.
3. WRONG squash: queue in order A (bit0, wrong, dep 00000), B (bit1, dep 00001), C (bit2, dep 00000) -> WRONG with rs=00000, then CORRECT with dep_o=00011 and rs=00000 for C. B never appears; count_o reaches 0.
4. Retire filter on inputs: while br_state_o=WRONG for bit1, present ex0 with dep=00010 and bit=00100 -> it is never enqueued and count_o is unchanged.
5. Backpressure (DEPTH=4): enqueue 2+1 entries while head is blocked from leaving by back-to-back fills, so count_o=3 -> ex_ready_o=0; ex inputs are ignored until count_o<=2.
6. Reset mid-op: 3 queued plus an output CORRECT, assert rst one cycle -> next cycle br_state=NONE, count_o=0, ex_ready_o=1, and nothing is issued afterwards.
